spi_master_param: RTL and testbench

SPI_MASTER_PARAM -- requirements
Module: spi_master_param

---
 rtl/spi_master_param.sv | 208 ++++++++++++++++++++
 tb/tb_spi_master_param.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/spi_master_param.sv
// SPI master with per-frame configuration.
// A frame is captured at start (data, slave index, CPOL/CPHA, bit order, divider)
// and then runs SETUP -> XFER -> HOLD -> IDLE, independent of later input changes.
// Every phase of the frame is measured in half-periods of clk_div+1 clk cycles.
module spi_master_param #(
    parameter int DATA_W = 8,
    parameter int NUM_SS = 4,
    parameter int DIV_W  = 8,
    localparam int SSW   = (NUM_SS > 1) ? $clog2(NUM_SS) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_transaction,
    input  logic [DATA_W-1:0] tx_data,
    input  logic [SSW-1:0]    ss_sel,
    input  logic              cpol,
    input  logic              cpha,
    input  logic              lsb_first,
    input  logic [DIV_W-1:0]  clk_div,
    input  logic              miso,
    output logic              sclk,
    output logic              mosi,
    output logic [NUM_SS-1:0] ss_n,
    output logic [DATA_W-1:0] rx_data,
    output logic              transaction_done,
    output logic              busy
);

    // Edge counter covers 2*DATA_W SCLK edges per frame.
    localparam int EW = $clog2(2 * DATA_W);
    localparam logic [EW-1:0] LAST_EDGE = EW'(2 * DATA_W - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        XFER  = 2'd2,
        HOLD  = 2'd3
    } state_t;

    state_t            state_q;
    state_t            state_d;

    // Control counters
    logic [DIV_W-1:0]  div_cnt_q;
    logic [EW-1:0]     edge_cnt_q;

    // Per-frame captured configuration and shift registers
    logic [DIV_W-1:0]  div_q;
    logic              cpha_q;
    logic              lsb_q;
    logic [DATA_W-1:0] tx_sh;
    logic [DATA_W-1:0] rx_sh;

    // Strobes decoded from the current state
    logic accept;
    logic half_end;
    logic edge_evt;
    logic last_edge;
    logic finish;
    logic leading;
    logic sample_evt;
    logic shift_evt;

    // Active-low one-hot select; an index beyond NUM_SS selects nobody.
    function automatic logic [NUM_SS-1:0] ss_decode(input logic [SSW-1:0] sel);
        logic [NUM_SS-1:0] dec;
        dec = '1;
        for (int i = 0; i < NUM_SS; i++) begin
            if (int'(sel) == i) begin
                dec[i] = 1'b0;
            end
        end
        return dec;
    endfunction

    // First bit of a frame, chosen by the requested bit order.
    function automatic logic first_bit(input logic [DATA_W-1:0] d, input logic lsb);
        return lsb ? d[0] : d[DATA_W-1];
    endfunction

    // Next-state logic and per-cycle strobes.
    always_comb begin
        state_d   = state_q;
        accept    = 1'b0;
        edge_evt  = 1'b0;
        last_edge = 1'b0;
        finish    = 1'b0;
        half_end  = (div_cnt_q == div_q);
        case (state_q)
            // The done cycle is spent in IDLE, so a start present there is
            // taken at once: a held start gives back-to-back frames.
            IDLE: begin
                if (start_transaction) begin
                    accept  = 1'b1;
                    state_d = SETUP;
                end
            end
            SETUP: begin
                if (half_end) begin
                    state_d = XFER;
                end
            end
            // Each XFER half-period ends with one SCLK edge; the final edge
            // brings SCLK back to its idle level as HOLD is entered.
            XFER: begin
                if (half_end) begin
                    edge_evt = 1'b1;
                    if (edge_cnt_q == LAST_EDGE) begin
                        last_edge = 1'b1;
                        state_d   = HOLD;
                    end
                end
            end
            HOLD: begin
                if (half_end) begin
                    finish  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Even-numbered edges are leading edges. CPHA=0 samples on leading and
    // shifts on trailing; CPHA=1 is the reverse. The first bit is already on
    // mosi from SETUP, so the very first edge never shifts, and nothing is
    // shifted past the final bit.
    assign leading    = ~edge_cnt_q[0];
    assign sample_evt = edge_evt & (leading != cpha_q);
    assign shift_evt  = edge_evt & (leading == cpha_q) & (edge_cnt_q != '0) & ~last_edge;

    assign busy = (state_q != IDLE) | transaction_done;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Half-period and edge counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt_q  <= '0;
            edge_cnt_q <= '0;
        end else begin
            if (state_q == IDLE || half_end) begin
                div_cnt_q <= '0;
            end else begin
                div_cnt_q <= div_cnt_q + DIV_W'(1);
            end
            if (accept) begin
                edge_cnt_q <= '0;
            end else if (edge_evt) begin
                edge_cnt_q <= edge_cnt_q + EW'(1);
            end
        end
    end

    // Serial outputs, selects, completion pulse and received word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk             <= 1'b0;
            mosi             <= 1'b0;
            ss_n             <= '1;
            rx_data          <= '0;
            transaction_done <= 1'b0;
        end else begin
            transaction_done <= finish;
            if (accept) begin
                sclk <= cpol;
                mosi <= first_bit(tx_data, lsb_first);
                ss_n <= ss_decode(ss_sel);
            end else begin
                if (edge_evt) begin
                    sclk <= ~sclk;
                end
                if (shift_evt) begin
                    mosi <= lsb_q ? tx_sh[1] : tx_sh[DATA_W-2];
                end
                if (finish) begin
                    mosi    <= 1'b0;
                    ss_n    <= '1;
                    rx_data <= rx_sh;
                end
            end
        end
    end

    // Frame configuration capture and data shift registers (no reset needed:
    // every field is loaded at accept before it is used).
    always_ff @(posedge clk) begin
        if (accept) begin
            tx_sh  <= tx_data;
            div_q  <= clk_div;
            cpha_q <= cpha;
            lsb_q  <= lsb_first;
        end else if (shift_evt) begin
            tx_sh <= lsb_q ? (tx_sh >> 1) : (tx_sh << 1);
        end
        if (sample_evt) begin
            rx_sh <= lsb_q ? {miso, rx_sh[DATA_W-1:1]} : {rx_sh[DATA_W-2:0], miso};
        end
    end

endmodule

// File: tb/tb_spi_master_param.sv
// Directed bench for spi_master_param: an 8-bit / 4-select instance and a
// 16-bit / 5-select instance share the clock and reset.
module tb_spi_master_param;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    // 8-bit instance signals
    logic       start8 = 1'b0;
    logic [7:0] tx8 = '0;
    logic [1:0] sel8 = '0;
    logic       cpol8 = 1'b0, cpha8 = 1'b0, lsb8 = 1'b0;
    logic [7:0] div8 = '0;
    logic       loop8 = 1'b0, miso_fix8 = 1'b0;
    logic       miso8, sclk8, mosi8, done8, busy8;
    logic [3:0] ss_n8;
    logic [7:0] rx8;

    // 16-bit instance signals
    logic        start16 = 1'b0;
    logic [15:0] tx16 = '0;
    logic [2:0]  sel16 = '0;
    logic        cpol16 = 1'b0, cpha16 = 1'b0, lsb16 = 1'b0;
    logic [7:0]  div16 = '0;
    logic        miso16, sclk16, mosi16, done16, busy16;
    logic [4:0]  ss_n16;
    logic [15:0] rx16;

    int n_err = 0;
    int n_checks = 0;
    int pcnt = 0;
    int ndone8 = 0;
    logic       sclk8_prev = 1'b0;
    logic [7:0] cap8 = '0;

    assign miso8  = loop8 ? mosi8 : miso_fix8;
    assign miso16 = mosi16;

    spi_master_param #(.DATA_W(8), .NUM_SS(4), .DIV_W(8)) u8 (
        .clk(clk), .rst_n(rst_n), .start_transaction(start8), .tx_data(tx8),
        .ss_sel(sel8), .cpol(cpol8), .cpha(cpha8), .lsb_first(lsb8), .clk_div(div8),
        .miso(miso8), .sclk(sclk8), .mosi(mosi8), .ss_n(ss_n8), .rx_data(rx8),
        .transaction_done(done8), .busy(busy8)
    );

    spi_master_param #(.DATA_W(16), .NUM_SS(5), .DIV_W(8)) u16 (
        .clk(clk), .rst_n(rst_n), .start_transaction(start16), .tx_data(tx16),
        .ss_sel(sel16), .cpol(cpol16), .cpha(cpha16), .lsb_first(lsb16), .clk_div(div16),
        .miso(miso16), .sclk(sclk16), .mosi(mosi16), .ss_n(ss_n16), .rx_data(rx16),
        .transaction_done(done16), .busy(busy16)
    );

    always #5 clk = ~clk;

    // Free-running edge counter used as a timestamp.
    always @(posedge clk) pcnt <= pcnt + 1;

    // Count completion pulses of the 8-bit instance.
    always @(posedge clk) if (done8) ndone8 <= ndone8 + 1;

    // Record mosi each time sclk has just risen (slave sample point in modes 0 and 3).
    always @(posedge clk) begin
        sclk8_prev <= sclk8;
        if (sclk8 && !sclk8_prev) cap8 <= {cap8[6:0], mosi8};
    end

    // Hard stop in case the sequence never finishes.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_done(input int which, input int t0, input int limit, output int lat);
        lat = -1;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if ((which == 8 && done8 === 1'b1) || (which == 16 && done16 === 1'b1)) begin
                lat = pcnt - t0;
                break;
            end
        end
    endtask

    initial begin
        int t0;
        int lat;
        int base;

        // Reset values
        repeat (3) @(negedge clk);
        chk("rst sclk", 32'(sclk8), 'h0);
        chk("rst mosi", 32'(mosi8), 'h0);
        chk("rst ss_n", 32'(ss_n8), 'hF);
        chk("rst busy", 32'(busy8), 'h0);
        chk("rst done", 32'(done8), 'h0);
        chk("rst rx", 32'(rx8), 'h0);
        chk("rst ss_n16", 32'(ss_n16), 'h1F);
        rst_n = 1'b1;
        @(negedge clk);

        // Frame A: mode 0, div 1, MSB first, 0x99 looped back, slave 2
        cpol8 = 0; cpha8 = 0; lsb8 = 0; div8 = 1; tx8 = 8'h99; sel8 = 2; loop8 = 1;
        start8 = 1; t0 = pcnt;
        @(negedge clk); start8 = 0;
        chk("A ss_n first", 32'(ss_n8), 'hB);
        chk("A busy first", 32'(busy8), 'h1);
        chk("A mosi first", 32'(mosi8), 'h1);
        tx8 = 8'h00; sel8 = 0; div8 = 5; lsb8 = 1; cpha8 = 1;
        repeat (9) @(negedge clk);
        start8 = 1;
        @(negedge clk); start8 = 0;
        chk("A ss_n mid", 32'(ss_n8), 'hB);
        wait_done(8, t0, 200, lat);
        chk("A latency", 32'(lat), 37);
        chk("A rx", 32'(rx8), 'h99);
        chk("A mosi bits", 32'(cap8), 'h99);
        chk("A ss_n at done", 32'(ss_n8), 'hF);
        chk("A busy at done", 32'(busy8), 'h1);
        @(negedge clk);
        chk("A done width", 32'(done8), 'h0);
        chk("A busy after", 32'(busy8), 'h0);
        chk("A mosi idle", 32'(mosi8), 'h0);

        // Frame B: mode 3, div 0, LSB first, 0xBB, miso tied high, slave 0
        cpol8 = 1; cpha8 = 1; lsb8 = 1; div8 = 0; tx8 = 8'hBB; sel8 = 0; loop8 = 0; miso_fix8 = 1;
        start8 = 1; t0 = pcnt;
        @(negedge clk); start8 = 0;
        chk("B sclk setup", 32'(sclk8), 'h1);
        chk("B ss_n first", 32'(ss_n8), 'hE);
        chk("B mosi first", 32'(mosi8), 'h1);
        wait_done(8, t0, 200, lat);
        chk("B latency", 32'(lat), 19);
        chk("B rx", 32'(rx8), 'hFF);
        chk("B mosi order", 32'(cap8), 'hDD);
        repeat (5) @(negedge clk);
        chk("B sclk idle high", 32'(sclk8), 'h1);
        chk("B rx holds", 32'(rx8), 'hFF);

        // Frame C: start held for three back-to-back mode-0 frames
        cpol8 = 0; cpha8 = 0; lsb8 = 0; div8 = 1; tx8 = 8'h3C; sel8 = 1; loop8 = 1;
        start8 = 1; t0 = pcnt;
        @(negedge clk);
        chk("C ss_n first", 32'(ss_n8), 'hD);
        repeat (4) @(negedge clk);
        tx8 = 8'h5A; div8 = 3; lsb8 = 1; cpol8 = 1;
        repeat (10) @(negedge clk);
        div8 = 1; lsb8 = 0; cpol8 = 0;
        wait_done(8, t0, 200, lat);
        chk("C1 period", 32'(lat), 37);
        chk("C1 rx", 32'(rx8), 'h3C);
        chk("C1 mosi bits", 32'(cap8), 'h3C);
        t0 = pcnt;
        repeat (4) @(negedge clk);
        tx8 = 8'hC3;
        wait_done(8, t0, 200, lat);
        chk("C2 period", 32'(lat), 37);
        chk("C2 rx", 32'(rx8), 'h5A);
        chk("C2 mosi bits", 32'(cap8), 'h5A);
        t0 = pcnt;
        repeat (4) @(negedge clk);
        start8 = 0; tx8 = 8'h00;
        wait_done(8, t0, 200, lat);
        chk("C3 period", 32'(lat), 37);
        chk("C3 rx", 32'(rx8), 'hC3);
        @(negedge clk);
        chk("C no fourth frame", 32'(busy8), 'h0);

        // Frame D: reset asserted around bit 4, between clock edges
        tx8 = 8'hF0; sel8 = 3;
        start8 = 1;
        @(negedge clk); start8 = 0;
        repeat (19) @(negedge clk);
        chk("D busy before reset", 32'(busy8), 'h1);
        base = ndone8;
        #2 rst_n = 1'b0;
        #1;
        chk("D rst sclk", 32'(sclk8), 'h0);
        chk("D rst mosi", 32'(mosi8), 'h0);
        chk("D rst ss_n", 32'(ss_n8), 'hF);
        chk("D rst busy", 32'(busy8), 'h0);
        chk("D rst done", 32'(done8), 'h0);
        chk("D rst rx", 32'(rx8), 'h0);
        @(negedge clk); rst_n = 1'b1;
        repeat (60) @(negedge clk);
        chk("D no done pulse", 32'(ndone8 - base), 'h0);

        // Frame E: normal frame after the aborted one
        tx8 = 8'h66; sel8 = 0;
        start8 = 1; t0 = pcnt;
        @(negedge clk); start8 = 0;
        chk("E ss_n first", 32'(ss_n8), 'hE);
        wait_done(8, t0, 200, lat);
        chk("E latency", 32'(lat), 37);
        chk("E rx", 32'(rx8), 'h66);

        // Frame F: 16-bit mode 1, div 2, 0xA5C3 looped back, out-of-range slave 5
        cpol16 = 0; cpha16 = 1; lsb16 = 0; div16 = 2; tx16 = 16'hA5C3; sel16 = 5;
        start16 = 1; t0 = pcnt;
        @(negedge clk); start16 = 0;
        chk("F ss_n none", 32'(ss_n16), 'h1F);
        chk("F busy", 32'(busy16), 'h1);
        chk("F mosi first", 32'(mosi16), 'h1);
        repeat (40) @(negedge clk);
        chk("F ss_n mid", 32'(ss_n16), 'h1F);
        wait_done(16, t0, 400, lat);
        chk("F latency", 32'(lat), 103);
        chk("F rx", 32'(rx16), 'hA5C3);

        // Frame G: 16-bit mode 1, div 0, LSB first, slave 4
        lsb16 = 1; div16 = 0; tx16 = 16'h1234; sel16 = 4;
        start16 = 1; t0 = pcnt;
        @(negedge clk); start16 = 0;
        chk("G ss_n first", 32'(ss_n16), 'h0F);
        chk("G mosi first", 32'(mosi16), 'h0);
        wait_done(16, t0, 400, lat);
        chk("G latency", 32'(lat), 35);
        chk("G rx", 32'(rx16), 'h1234);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
